// File: rtl/xbar_pkg.sv
// Shared widths and types for the 4x4 round-robin crossbar.
// Optional burst locking is enabled with XBAR_LOCK_EN.
package xbar_pkg;
  localparam int XBAR_PORTS = 4;
  localparam int XBAR_IDX_W = 2;

  typedef logic [XBAR_IDX_W-1:0] port_idx_t;
  typedef logic [XBAR_PORTS-1:0] port_vec_t;
endpackage

// File: rtl/xbar_rr_switch_if.sv
// Producer/consumer bundle of the crossbar; master drives inputs and consumer ready.
// IN_LAST exists only when XBAR_LOCK_EN is defined.
interface xbar_rr_switch_if #(parameter int WL = 16);
  logic [WL-1:0] IN0, IN1, IN2, IN3;
  logic [1:0]    IN_DEST0, IN_DEST1, IN_DEST2, IN_DEST3;
  logic [3:0]    IN_VALID;
  logic [3:0]    IN_READY;
`ifdef XBAR_LOCK_EN
  logic [3:0]    IN_LAST;
`endif
  logic [WL-1:0] OUT0, OUT1, OUT2, OUT3;
  logic [3:0]    OUT_VALID;
  logic [3:0]    OUT_READY;

  modport master (
`ifdef XBAR_LOCK_EN
    output IN_LAST,
`endif
    output IN0, IN1, IN2, IN3, IN_DEST0, IN_DEST1, IN_DEST2, IN_DEST3, IN_VALID,
    input  IN_READY,
    input  OUT0, OUT1, OUT2, OUT3, OUT_VALID,
    output OUT_READY
  );

  modport slave (
`ifdef XBAR_LOCK_EN
    input  IN_LAST,
`endif
    input  IN0, IN1, IN2, IN3, IN_DEST0, IN_DEST1, IN_DEST2, IN_DEST3, IN_VALID,
    output IN_READY,
    output OUT0, OUT1, OUT2, OUT3, OUT_VALID,
    input  OUT_READY
  );
endinterface

// File: rtl/xbar_rr_switch_rr_arb4.sv
// 4-way round-robin arbiter with a 2-bit rotating pointer; grants only when en is high.
// With XBAR_LOCK_EN the winner holds the arbiter until its IN_LAST word is granted.
module rr_arb4
  import xbar_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  port_vec_t req,
  input  logic      en,
`ifdef XBAR_LOCK_EN
  input  port_vec_t last,
`endif
  output port_vec_t gnt
);
  port_idx_t ptr_q, ptr_d;
  port_idx_t pick;
  port_idx_t idx;
  logic      hit;

  // Scan backwards so the requester closest to the pointer wins.
  always_comb begin
    hit  = 1'b0;
    pick = ptr_q;
    idx  = ptr_q;
    for (int off = XBAR_PORTS - 1; off >= 0; off--) begin
      idx = ptr_q + port_idx_t'(off);
      if (req[idx]) begin
        hit  = 1'b1;
        pick = idx;
      end
    end
  end

`ifdef XBAR_LOCK_EN
  logic      lock_q, lock_d;
  port_idx_t own_q, own_d;

  always_comb begin
    gnt    = '0;
    ptr_d  = ptr_q;
    lock_d = lock_q;
    own_d  = own_q;
    if (lock_q) begin
      if (en && req[own_q]) begin
        gnt[own_q] = 1'b1;
        if (last[own_q]) begin
          lock_d = 1'b0;
          ptr_d  = own_q + 2'd1;
        end
      end
    end else if (en && hit) begin
      gnt[pick] = 1'b1;
      if (last[pick]) begin
        ptr_d = pick + 2'd1;
      end else begin
        lock_d = 1'b1;
        own_d  = pick;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= 1'b0;
      own_q  <= '0;
    end else begin
      lock_q <= lock_d;
      own_q  <= own_d;
    end
  end
`else
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    if (en && hit) begin
      gnt[pick] = 1'b1;
      ptr_d     = pick + 2'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/xbar_rr_switch.sv
// 4x4 request-driven crossbar: per-output round-robin arbiter feeding one registered slot.
// XBAR_LOCK_EN adds burst locking via IN_LAST.
module xbar_rr_switch
  import xbar_pkg::*;
#(
  parameter int WL = 16
) (
  input logic             clk,
  input logic             rst_n,
  xbar_rr_switch_if.slave io
);
  logic [WL-1:0] in_dat [XBAR_PORTS];
  port_idx_t     in_dest [XBAR_PORTS];
  port_vec_t     req [XBAR_PORTS];
  port_vec_t     gnt [XBAR_PORTS];
  port_vec_t     slot_en;
  port_vec_t     in_rdy;

  logic [WL-1:0] out_dat_q [XBAR_PORTS];
  logic [WL-1:0] out_dat_d [XBAR_PORTS];
  port_vec_t     out_vld_q, out_vld_d;

  assign in_dat[0] = io.IN0;
  assign in_dat[1] = io.IN1;
  assign in_dat[2] = io.IN2;
  assign in_dat[3] = io.IN3;
  assign in_dest[0] = io.IN_DEST0;
  assign in_dest[1] = io.IN_DEST1;
  assign in_dest[2] = io.IN_DEST2;
  assign in_dest[3] = io.IN_DEST3;

  // A slot may refill in the same cycle its current word drains.
  always_comb begin
    for (int j = 0; j < XBAR_PORTS; j++) begin
      slot_en[j] = !out_vld_q[j] || io.OUT_READY[j];
      for (int i = 0; i < XBAR_PORTS; i++) begin
        req[j][i] = io.IN_VALID[i] && (in_dest[i] == port_idx_t'(j));
      end
    end
  end

  for (genvar j = 0; j < XBAR_PORTS; j++) begin : g_arb
    rr_arb4 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req[j]),
      .en    (slot_en[j]),
`ifdef XBAR_LOCK_EN
      .last  (io.IN_LAST),
`endif
      .gnt   (gnt[j])
    );
  end

  always_comb begin
    in_rdy = '0;
    for (int j = 0; j < XBAR_PORTS; j++) begin
      in_rdy    = in_rdy | gnt[j];
      out_vld_d[j] = out_vld_q[j] && !io.OUT_READY[j];
      out_dat_d[j] = out_dat_q[j];
      for (int i = 0; i < XBAR_PORTS; i++) begin
        if (gnt[j][i]) begin
          out_vld_d[j] = 1'b1;
          out_dat_d[j] = in_dat[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= '0;
      for (int j = 0; j < XBAR_PORTS; j++) out_dat_q[j] <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      for (int j = 0; j < XBAR_PORTS; j++) out_dat_q[j] <= out_dat_d[j];
    end
  end

  assign io.IN_READY  = in_rdy;
  assign io.OUT_VALID = out_vld_q;
  assign io.OUT0      = out_dat_q[0];
  assign io.OUT1      = out_dat_q[1];
  assign io.OUT2      = out_dat_q[2];
  assign io.OUT3      = out_dat_q[3];
endmodule

// File: tb/tb_xbar_rr_switch.sv
// Bench for xbar_rr_switch: random traffic against a queue-free reference model,
// a directed vector table, and hand sequences for contention, reset and burst locking.
module tb_xbar_rr_switch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xbar_rr_switch_if #(.WL(16)) io();
  xbar_rr_switch #(.WL(16)) dut (.clk(clk), .rst_n(rst_n), .io(io));

  int n_vec = 0;
  int n_bad = 0;

  logic [3:0]  t_vld, t_ordy;
  logic [1:0]  t_dest [4];
  logic [15:0] t_dat [4];
`ifdef XBAR_LOCK_EN
  logic [3:0]  t_last;
`endif

  // Reference model: one held word per output, one pointer per output.
  logic [3:0]  m_vld;
  logic [15:0] m_dat [4];
  int          m_ptr [4];
  int          m_g [4];
  logic [3:0]  m_rdy;

  typedef struct packed {
    logic [3:0]        vld;
    logic [3:0][1:0]   dest;
    logic [3:0][15:0]  dat;
    logic [3:0]        ordy;
    logic [3:0]        irdy;
    logic [3:0]        ovld;
    logic [3:0][15:0]  out;
  } vec_t;

  vec_t tv [17];

  function automatic logic [7:0] D(input int d0, input int d1, input int d2, input int d3);
    return {2'(d3), 2'(d2), 2'(d1), 2'(d0)};
  endfunction

  function automatic logic [63:0] W(input logic [15:0] a0, input logic [15:0] a1,
                                    input logic [15:0] a2, input logic [15:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic vec_t mk(input logic [3:0] vld, input logic [7:0] dest, input logic [63:0] dat,
                              input logic [3:0] ordy, input logic [3:0] irdy, input logic [3:0] ovld,
                              input logic [63:0] out);
    vec_t v;
    v.vld = vld; v.dest = dest; v.dat = dat; v.ordy = ordy;
    v.irdy = irdy; v.ovld = ovld; v.out = out;
    return v;
  endfunction

  function automatic logic [63:0] outs();
    return {io.OUT3, io.OUT2, io.OUT1, io.OUT0};
  endfunction

  function automatic logic [63:0] mouts();
    return {m_dat[3], m_dat[2], m_dat[1], m_dat[0]};
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive();
    io.IN0 = t_dat[0]; io.IN1 = t_dat[1]; io.IN2 = t_dat[2]; io.IN3 = t_dat[3];
    io.IN_DEST0 = t_dest[0]; io.IN_DEST1 = t_dest[1];
    io.IN_DEST2 = t_dest[2]; io.IN_DEST3 = t_dest[3];
    io.IN_VALID = t_vld;
    io.OUT_READY = t_ordy;
`ifdef XBAR_LOCK_EN
    io.IN_LAST = t_last;
`endif
  endtask

  task automatic model_reset();
    m_vld = '0;
    for (int j = 0; j < 4; j++) begin
      m_dat[j] = '0;
      m_ptr[j] = 0;
    end
  endtask

  // Each output takes the first requester at or after its pointer, if its slot can take a word.
  task automatic model_eval();
    m_rdy = '0;
    for (int j = 0; j < 4; j++) begin
      m_g[j] = -1;
      if (!m_vld[j] || t_ordy[j]) begin
        for (int off = 0; off < 4 && m_g[j] < 0; off++) begin
          int i;
          i = (m_ptr[j] + off) % 4;
          if (t_vld[i] && int'(t_dest[i]) == j) m_g[j] = i;
        end
      end
      if (m_g[j] >= 0) m_rdy[m_g[j]] = 1'b1;
    end
  endtask

  task automatic model_commit();
    for (int j = 0; j < 4; j++) begin
      if (m_g[j] >= 0) begin
        m_vld[j] = 1'b1;
        m_dat[j] = t_dat[m_g[j]];
        m_ptr[j] = (m_g[j] + 1) % 4;
      end else if (t_ordy[j]) begin
        m_vld[j] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    t_vld = '0;
    t_ordy = '0;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] acc;
    for (int i = 0; i < 4; i++) begin
      t_dest[i] = '0;
      t_dat[i] = '0;
    end
`ifdef XBAR_LOCK_EN
    t_last = 4'hF;
`endif
    do_reset();
    check("reset_state", {8'h0, io.OUT_VALID, 4'h0, outs()}, 80'h0);

    // Random traffic that honours the hold-until-ready rule.
    acc = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) t_vld[i] = 1'b0;
        if (!t_vld[i] && $urandom_range(0, 2) != 0) begin
          t_vld[i] = 1'b1;
          t_dest[i] = 2'($urandom_range(0, 3));
          t_dat[i] = 16'($urandom);
        end
      end
      t_ordy = 4'($urandom);
      drive();
      @(negedge clk);
      model_eval();
      check("rand", {8'h0, io.IN_READY, io.OUT_VALID, outs()}, {8'h0, m_rdy, m_vld, mouts()});
      acc = m_rdy;
      model_commit();
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of traffic clears the slots immediately.
    #2 rst_n = 1'b0;
    #1 check("reset_async", {8'h0, io.OUT_VALID, 4'h0, outs()}, 80'h0);
    t_vld = '0;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    t_vld = 4'b0001; t_dest[0] = 2'd0; t_dat[0] = 16'h1234; t_ordy = 4'hF;
    drive();
    #1 check("rst_first_gnt", {76'h0, io.IN_READY}, 80'h1);
    @(posedge clk);
    #1 check("rst_first_out", {60'h0, io.OUT_VALID, io.OUT0}, {60'h0, 4'b0001, 16'h1234});
    t_vld = '0;
    drive();

    // Directed table, applied from reset with all pointers at 0.
    tv[0]  = mk(4'hF, D(3,2,1,0), W(16'h000A,16'h000B,16'h000C,16'h000D), 4'hF, 4'hF, 4'hF,
                W(16'h000D,16'h000C,16'h000B,16'h000A));
    tv[1]  = mk(4'h0, D(0,0,0,0), W(0,0,0,0), 4'hF, 4'h0, 4'h0,
                W(16'h000D,16'h000C,16'h000B,16'h000A));
    tv[2]  = mk(4'hF, D(1,1,1,1), W(16'h11,16'h12,16'h13,16'h14), 4'hF, 4'h8, 4'h2,
                W(16'h000D,16'h14,16'h000B,16'h000A));
    tv[3]  = mk(4'h7, D(1,1,1,1), W(16'h11,16'h12,16'h13,0), 4'hF, 4'h1, 4'h2,
                W(16'h000D,16'h11,16'h000B,16'h000A));
    tv[4]  = mk(4'h6, D(1,1,1,1), W(0,16'h12,16'h13,0), 4'hF, 4'h2, 4'h2,
                W(16'h000D,16'h12,16'h000B,16'h000A));
    tv[5]  = mk(4'h4, D(1,1,1,1), W(0,0,16'h13,0), 4'hF, 4'h4, 4'h2,
                W(16'h000D,16'h13,16'h000B,16'h000A));
    tv[6]  = mk(4'h0, D(0,0,0,0), W(0,0,0,0), 4'h0, 4'h0, 4'h2,
                W(16'h000D,16'h13,16'h000B,16'h000A));
    for (int k = 7; k < 11; k++)
      tv[k] = mk(4'h2, D(0,2,0,0), W(0,16'h55,0,0), 4'h0, 4'h0, 4'h2,
                 W(16'h000D,16'h13,16'h000B,16'h000A));
    tv[7].dest = D(0,1,0,0); tv[8].dest = D(0,1,0,0);
    tv[9].dest = D(0,1,0,0); tv[10].dest = D(0,1,0,0);
    tv[11] = mk(4'h2, D(0,1,0,0), W(0,16'h55,0,0), 4'h2, 4'h2, 4'h2,
                W(16'h000D,16'h55,16'h000B,16'h000A));
    tv[12] = mk(4'h0, D(0,0,0,0), W(0,0,0,0), 4'hF, 4'h0, 4'h0,
                W(16'h000D,16'h55,16'h000B,16'h000A));
    tv[13] = mk(4'hD, D(0,0,1,3), W(16'h21,0,16'h22,16'h23), 4'hF, 4'hD, 4'hB,
                W(16'h21,16'h22,16'h000B,16'h23));
    tv[14] = mk(4'hD, D(0,0,1,3), W(16'h31,0,16'h32,16'h33), 4'hE, 4'hC, 4'hB,
                W(16'h21,16'h32,16'h000B,16'h33));
    tv[15] = mk(4'hD, D(0,0,1,3), W(16'h31,0,16'h42,16'h43), 4'hE, 4'hC, 4'hB,
                W(16'h21,16'h42,16'h000B,16'h43));
    tv[16] = mk(4'h1, D(0,0,0,0), W(16'h31,0,0,0), 4'hF, 4'h1, 4'h1,
                W(16'h31,16'h42,16'h000B,16'h43));

    do_reset();
    for (int r = 0; r < 17; r++) begin
      t_vld = tv[r].vld;
      t_ordy = tv[r].ordy;
      for (int i = 0; i < 4; i++) begin
        t_dest[i] = tv[r].dest[i];
        t_dat[i] = tv[r].dat[i];
      end
      drive();
      @(negedge clk);
      check($sformatf("tbl%0d_irdy", r), {76'h0, io.IN_READY}, {76'h0, tv[r].irdy});
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_out", r), {12'h0, io.OUT_VALID, outs()}, {12'h0, tv[r].ovld, tv[r].out});
    end

    // Four inputs contend for output 1: served 0,1,2,3,0 on consecutive cycles.
    do_reset();
    t_ordy = 4'hF;
    for (int i = 0; i < 4; i++) begin
      t_dest[i] = 2'd1;
      t_dat[i] = 16'(16'h0100 * i);
    end
    t_vld = 4'hF;
    for (int c = 0; c < 5; c++) begin
      int k;
      logic [15:0] want;
      k = c % 4;
      want = t_dat[k];
      drive();
      @(negedge clk);
      check($sformatf("cont%0d_irdy", c), {76'h0, io.IN_READY}, {76'h0, 4'(1 << k)});
      @(posedge clk);
      #1;
      check($sformatf("cont%0d_out", c), {60'h0, io.OUT_VALID, io.OUT1}, {60'h0, 4'b0010, want});
      t_dat[k] = t_dat[k] + 16'h1;
    end

`ifdef XBAR_LOCK_EN
    // Input 0 bursts three words to output 0; input 1 waits for the last one.
    do_reset();
    t_ordy = 4'hF;
    t_dest[0] = 2'd0; t_dest[1] = 2'd0;
    t_dat[0] = 16'h00B1; t_dat[1] = 16'h00C1;
    t_vld = 4'b0011;
    t_last = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      logic [3:0] exp_rdy;
      logic [15:0] want;
      exp_rdy = (c < 3) ? 4'b0001 : 4'b0010;
      want = (c < 3) ? t_dat[0] : t_dat[1];
      if (c == 2) t_last[0] = 1'b1;
      if (c == 3) t_vld[0] = 1'b0;
      drive();
      @(negedge clk);
      check($sformatf("lock%0d_irdy", c), {76'h0, io.IN_READY}, {76'h0, exp_rdy});
      @(posedge clk);
      #1;
      check($sformatf("lock%0d_out", c), {64'h0, io.OUT0}, {64'h0, want});
      t_dat[0] = t_dat[0] + 16'h1;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
